// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch operand hazard stall, PC redirect
// and exception flush sequencer with taken/stall performance counters.
module branch_hazard_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0004,
    parameter int          EXC_FLUSH_CYC = 2,
    parameter int          CNT_W         = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_hold,
    input  logic             in_id_valid,
    input  logic [5:0]       in_id_op,
    input  logic [5:0]       in_id_func,
    input  logic [4:0]       in_id_rs,
    input  logic [4:0]       in_id_rt,
    input  logic             in_ex_wreg,
    input  logic             in_ex_load,
    input  logic [4:0]       in_ex_rd,
    input  logic             in_mem_wreg,
    input  logic             in_mem_load,
    input  logic [4:0]       in_mem_rd,
    input  logic             in_branch,
    input  logic [31:0]      in_target,
    input  logic             in_exception,
    output logic             out_stall,
    output logic             out_bubble,
    output logic             out_flush,
    output logic             out_redirect,
    output logic [31:0]      out_redirect_pc,
    output logic [1:0]       out_state,
    output logic [CNT_W-1:0] out_taken_cnt,
    output logic [CNT_W-1:0] out_stall_cnt
);
    localparam int FW = (EXC_FLUSH_CYC > 1) ? $clog2(EXC_FLUSH_CYC) : 1;
    localparam logic [FW-1:0] FLUSH_INIT = FW'(EXC_FLUSH_CYC - 1);
    localparam logic EXC_STAY = (EXC_FLUSH_CYC > 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_TEQ   = 6'h34;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_HAZ = 2'd1,
        S_EXC = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_scnt;
    logic [FW-1:0]    r_fcnt;
    logic [CNT_W-1:0] r_taken;
    logic [CNT_W-1:0] r_stalls;

    logic       w_is_br;
    logic       w_use_rs;
    logic       w_use_rt;
    logic       w_rs_on;
    logic       w_rt_on;
    logic       w_ex_hit;
    logic       w_mem_hit;
    logic [1:0] w_hz;
    logic       w_exc_take;
    logic       w_hz_take;
    logic       w_br_take;
    logic       w_haz_hold;
    logic       w_unused;

    // MEM ALU results are forwarded, so only MEM loads matter
    assign w_unused = in_mem_wreg;

    // Classify the ID instruction and which source registers it reads
    always_comb begin
        w_is_br  = 1'b0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        unique case (1'b1)
            (in_id_op == OP_BEQ) || (in_id_op == OP_BNE),
            (in_id_op == OP_SPECIAL) && (in_id_func == FUNC_TEQ): begin
                w_is_br  = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            (in_id_op == OP_REGIMM) && (in_id_rt == RT_BGEZ),
            (in_id_op == OP_SPECIAL) &&
                ((in_id_func == FUNC_JR) || (in_id_func == FUNC_JALR)): begin
                w_is_br  = 1'b1;
                w_use_rs = 1'b1;
            end
            (in_id_op == OP_J) || (in_id_op == OP_JAL): begin
                w_is_br  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_rs_on   = w_use_rs && (in_id_rs != 5'd0);
    assign w_rt_on   = w_use_rt && (in_id_rt != 5'd0);
    assign w_ex_hit  = (w_rs_on && (in_id_rs == in_ex_rd)) ||
                       (w_rt_on && (in_id_rt == in_ex_rd));
    assign w_mem_hit = (w_rs_on && (in_id_rs == in_mem_rd)) ||
                       (w_rt_on && (in_id_rt == in_mem_rd));

    // Cycles the branch operands are still in flight
    always_comb begin
        w_hz = 2'd0;
        if (in_id_valid && w_is_br) begin
            if (in_ex_load && w_ex_hit)
                w_hz = 2'd2;
            else if (in_ex_wreg && w_ex_hit)
                w_hz = 2'd1;
            else if (in_mem_load && w_mem_hit)
                w_hz = 2'd1;
        end
    end

    assign w_exc_take = in_rst && !in_hold && in_exception;
    assign w_hz_take  = in_rst && !in_hold && !in_exception &&
                        (r_state == S_RUN) && (w_hz != 2'd0);
    assign w_br_take  = in_rst && !in_hold && !in_exception &&
                        (r_state == S_RUN) && (w_hz == 2'd0) &&
                        in_id_valid && w_is_br && in_branch;
    assign w_haz_hold = in_rst && (r_state == S_HAZ) && !w_exc_take;

    assign out_redirect    = w_exc_take || w_br_take;
    assign out_redirect_pc = w_exc_take ? EXC_VECTOR :
                             (w_br_take ? in_target : 32'd0);
    assign out_flush       = in_rst && ((r_state == S_EXC) || w_exc_take);
    assign out_stall       = in_rst && (in_hold || w_hz_take || w_haz_hold);
    assign out_bubble      = w_hz_take || w_haz_hold;
    assign out_state       = r_state;
    assign out_taken_cnt   = r_taken;
    assign out_stall_cnt   = r_stalls;

    // Sequencer state, stall/flush countdowns and perf counters
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state  <= S_RUN;
            r_scnt   <= 2'd0;
            r_fcnt   <= '0;
            r_taken  <= '0;
            r_stalls <= '0;
        end else if (!in_hold) begin
            if (in_exception) begin
                r_state <= EXC_STAY ? S_EXC : S_RUN;
                r_fcnt  <= FLUSH_INIT;
                r_scnt  <= 2'd0;
            end else begin
                unique case (r_state)
                    S_RUN: begin
                        if (w_hz != 2'd0) begin
                            r_scnt  <= w_hz - 2'd1;
                            r_state <= (w_hz == 2'd2) ? S_HAZ : S_RUN;
                        end else if (w_br_take) begin
                            r_taken <= r_taken + CNT_W'(1);
                        end
                    end
                    S_HAZ: begin
                        if (r_scnt <= 2'd1)
                            r_state <= S_RUN;
                        if (r_scnt != 2'd0)
                            r_scnt <= r_scnt - 2'd1;
                    end
                    S_EXC: begin
                        if (r_fcnt <= FW'(1))
                            r_state <= S_RUN;
                        if (r_fcnt != '0)
                            r_fcnt <= r_fcnt - FW'(1);
                    end
                    default: r_state <= S_RUN;
                endcase
                if ((w_hz_take || w_haz_hold) && (r_stalls != '1))
                    r_stalls <= r_stalls + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed scenario bench for branch_hazard_ctrl.
// Flags are compared as {stall, bubble, flush, redirect}.
module tb_branch_hazard_ctrl;
    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_hold;
    logic        in_id_valid;
    logic [5:0]  in_id_op;
    logic [5:0]  in_id_func;
    logic [4:0]  in_id_rs;
    logic [4:0]  in_id_rt;
    logic        in_ex_wreg;
    logic        in_ex_load;
    logic [4:0]  in_ex_rd;
    logic        in_mem_wreg;
    logic        in_mem_load;
    logic [4:0]  in_mem_rd;
    logic        in_branch;
    logic [31:0] in_target;
    logic        in_exception;
    logic        out_stall;
    logic        out_bubble;
    logic        out_flush;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;
    logic [1:0]  out_state;
    logic [15:0] out_taken_cnt;
    logic [15:0] out_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_taken = 16'd0;
    logic [15:0] exp_stall = 16'd0;
    wire  [3:0]  flags = {out_stall, out_bubble, out_flush, out_redirect};

    always #5 in_clk = ~in_clk;

    branch_hazard_ctrl dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_hold(in_hold),
        .in_id_valid(in_id_valid), .in_id_op(in_id_op),
        .in_id_func(in_id_func), .in_id_rs(in_id_rs), .in_id_rt(in_id_rt),
        .in_ex_wreg(in_ex_wreg), .in_ex_load(in_ex_load),
        .in_ex_rd(in_ex_rd), .in_mem_wreg(in_mem_wreg),
        .in_mem_load(in_mem_load), .in_mem_rd(in_mem_rd),
        .in_branch(in_branch), .in_target(in_target),
        .in_exception(in_exception), .out_stall(out_stall),
        .out_bubble(out_bubble), .out_flush(out_flush),
        .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
        .out_state(out_state), .out_taken_cnt(out_taken_cnt),
        .out_stall_cnt(out_stall_cnt)
    );

    task automatic tick;
        @(posedge in_clk);
        #1;
    endtask

    task automatic clr;
        in_hold = 0; in_id_valid = 0; in_id_op = 0; in_id_func = 0;
        in_id_rs = 0; in_id_rt = 0; in_ex_wreg = 0; in_ex_load = 0;
        in_ex_rd = 0; in_mem_wreg = 0; in_mem_load = 0; in_mem_rd = 0;
        in_branch = 0; in_target = 0; in_exception = 0;
    endtask

    task automatic id_set(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] tgt);
        in_id_valid = 1; in_id_op = op; in_id_func = fn;
        in_id_rs = rs; in_id_rt = rt; in_branch = 1; in_target = tgt;
    endtask

    task automatic test_reset;
        clr();
        in_rst = 0; in_hold = 1; in_exception = 1;
        id_set(6'h04, 6'h00, 5'd1, 5'd2, 32'h1234_5678);
        #3;
        n_cmp++; if (flags !== 4'b0000) begin n_bad++;
            $display("FAIL rst_flags got=%b exp=0000", flags); end
        n_cmp++; if (out_redirect_pc !== 32'd0) begin n_bad++;
            $display("FAIL rst_pc got=%h exp=0", out_redirect_pc); end
        n_cmp++; if (out_state !== 2'd0) begin n_bad++;
            $display("FAIL rst_state got=%0d exp=0", out_state); end
        n_cmp++; if ({out_taken_cnt, out_stall_cnt} !== 32'd0) begin n_bad++;
            $display("FAIL rst_cnts got=%h/%h exp=0/0",
                     out_taken_cnt, out_stall_cnt); end
        tick();
        clr();
        in_rst = 1;
        tick();
    endtask

    task automatic test_beq;
        id_set(6'h04, 6'h00, 5'd1, 5'd2, 32'h0040_0010);
        #1;
        n_cmp++; if (flags !== 4'b0001) begin n_bad++;
            $display("FAIL beq_flags got=%b exp=0001", flags); end
        n_cmp++; if (out_redirect_pc !== 32'h0040_0010) begin n_bad++;
            $display("FAIL beq_pc got=%h exp=00400010", out_redirect_pc); end
        tick(); exp_taken++;
        n_cmp++; if (out_taken_cnt !== exp_taken) begin n_bad++;
            $display("FAIL beq_taken got=%0d exp=%0d", out_taken_cnt, exp_taken); end
        clr();
    endtask

    task automatic test_ignore;
        id_set(6'h00, 6'h21, 5'd1, 5'd2, 32'h0000_0100);
        #1;
        n_cmp++; if (flags !== 4'b0000) begin n_bad++;
            $display("FAIL ign_addu got=%b exp=0000", flags); end
        tick();
        id_set(6'h04, 6'h00, 5'd5, 5'd2, 32'h0000_0200);
        in_id_valid = 0; in_ex_load = 1; in_ex_wreg = 1; in_ex_rd = 5'd5;
        #1;
        n_cmp++; if (flags !== 4'b0000) begin n_bad++;
            $display("FAIL ign_invalid got=%b exp=0000", flags); end
        tick();
        n_cmp++; if (out_taken_cnt !== exp_taken) begin n_bad++;
            $display("FAIL ign_taken got=%0d exp=%0d", out_taken_cnt, exp_taken); end
        clr();
    endtask

    task automatic test_load_use;
        id_set(6'h05, 6'h00, 5'd5, 5'd6, 32'h0040_0080);
        in_ex_load = 1; in_ex_wreg = 1; in_ex_rd = 5'd5;
        #1;
        n_cmp++; if (flags !== 4'b1100) begin n_bad++;
            $display("FAIL lu_c1 got=%b exp=1100", flags); end
        tick(); exp_stall++;
        n_cmp++; if (out_state !== 2'd1) begin n_bad++;
            $display("FAIL lu_haz got=%0d exp=1", out_state); end
        in_ex_load = 0; in_ex_wreg = 0; in_ex_rd = 0;
        in_mem_load = 1; in_mem_wreg = 1; in_mem_rd = 5'd5;
        #1;
        n_cmp++; if (flags !== 4'b1100) begin n_bad++;
            $display("FAIL lu_c2 got=%b exp=1100", flags); end
        tick(); exp_stall++;
        n_cmp++; if ({out_state, out_stall_cnt} !== {2'd0, exp_stall}) begin n_bad++;
            $display("FAIL lu_back got=%0d/%0d exp=0/%0d",
                     out_state, out_stall_cnt, exp_stall); end
        in_mem_load = 0; in_mem_wreg = 0; in_mem_rd = 0;
        #1;
        n_cmp++; if ({flags, out_redirect_pc} !== {4'b0001, 32'h0040_0080}) begin
            n_bad++;
            $display("FAIL lu_c3 got=%b/%h exp=0001/00400080", flags, out_redirect_pc); end
        tick(); exp_taken++;
        n_cmp++; if (out_taken_cnt !== exp_taken) begin n_bad++;
            $display("FAIL lu_taken got=%0d exp=%0d", out_taken_cnt, exp_taken); end
        clr();
    endtask

    task automatic test_alu_jr;
        id_set(6'h00, 6'h08, 5'd3, 5'd0, 32'h0000_3000);
        in_ex_wreg = 1; in_ex_rd = 5'd3;
        #1;
        n_cmp++; if (flags !== 4'b1100) begin n_bad++;
            $display("FAIL jr_stall got=%b exp=1100", flags); end
        tick(); exp_stall++;
        n_cmp++; if ({out_state, out_stall_cnt} !== {2'd0, exp_stall}) begin n_bad++;
            $display("FAIL jr_run got=%0d/%0d exp=0/%0d",
                     out_state, out_stall_cnt, exp_stall); end
        in_ex_wreg = 0; in_ex_rd = 0;
        #1;
        n_cmp++; if ({flags, out_redirect_pc} !== {4'b0001, 32'h0000_3000}) begin
            n_bad++;
            $display("FAIL jr_redir got=%b/%h exp=0001/00003000", flags, out_redirect_pc); end
        tick(); exp_taken++;
        id_set(6'h00, 6'h08, 5'd0, 5'd0, 32'h0000_3100);
        in_ex_wreg = 1; in_ex_load = 1; in_ex_rd = 5'd0;
        #1;
        n_cmp++; if (flags !== 4'b0001) begin n_bad++;
            $display("FAIL jr_r0 got=%b exp=0001", flags); end
        tick(); exp_taken++;
        clr();
    endtask

    task automatic test_classes;
        id_set(6'h02, 6'h00, 5'd4, 5'd4, 32'h0000_4000);
        in_ex_load = 1; in_ex_wreg = 1; in_ex_rd = 5'd4;
        #1;
        n_cmp++; if (flags !== 4'b0001) begin n_bad++;
            $display("FAIL cls_j got=%b exp=0001", flags); end
        tick(); exp_taken++;
        id_set(6'h01, 6'h00, 5'd7, 5'd1, 32'h0000_4100);
        in_ex_rd = 5'd1;
        #1;
        n_cmp++; if (flags !== 4'b0001) begin n_bad++;
            $display("FAIL cls_bgez got=%b exp=0001", flags); end
        tick(); exp_taken++;
        id_set(6'h00, 6'h34, 5'd8, 5'd9, 32'h0000_4200);
        in_ex_load = 0; in_ex_rd = 5'd9;
        #1;
        n_cmp++; if (flags !== 4'b1100) begin n_bad++;
            $display("FAIL cls_teq got=%b exp=1100", flags); end
        tick(); exp_stall++;
        in_ex_wreg = 0; in_ex_rd = 0;
        #1;
        n_cmp++; if (flags !== 4'b0001) begin n_bad++;
            $display("FAIL cls_teq2 got=%b exp=0001", flags); end
        tick(); exp_taken++;
        n_cmp++; if ({out_taken_cnt, out_stall_cnt} !== {exp_taken, exp_stall}) begin
            n_bad++;
            $display("FAIL cls_cnts got=%0d/%0d exp=%0d/%0d",
                     out_taken_cnt, out_stall_cnt, exp_taken, exp_stall); end
        clr();
    endtask

    task automatic test_exc_haz;
        id_set(6'h04, 6'h00, 5'd5, 5'd2, 32'h0000_5000);
        in_ex_load = 1; in_ex_wreg = 1; in_ex_rd = 5'd5;
        tick(); exp_stall++;
        in_ex_load = 0; in_ex_wreg = 0; in_ex_rd = 0;
        in_mem_load = 1; in_mem_wreg = 1; in_mem_rd = 5'd5;
        in_exception = 1;
        #1;
        n_cmp++; if ({flags, out_redirect_pc} !== {4'b0011, 32'h0000_0004}) begin
            n_bad++;
            $display("FAIL exc_entry got=%b/%h exp=0011/00000004", flags, out_redirect_pc); end
        tick();
        clr();
        #1;
        n_cmp++; if ({out_state, flags} !== {2'd2, 4'b0010}) begin n_bad++;
            $display("FAIL exc_hold got=%0d/%b exp=2/0010", out_state, flags); end
        tick();
        n_cmp++; if ({out_state, flags, out_stall_cnt} !== {2'd0, 4'b0000, exp_stall}) begin
            n_bad++;
            $display("FAIL exc_done got=%0d/%b/%0d exp=0/0000/%0d",
                     out_state, flags, out_stall_cnt, exp_stall); end
    endtask

    task automatic test_hold;
        id_set(6'h04, 6'h00, 5'd5, 5'd2, 32'h0000_6000);
        in_ex_load = 1; in_ex_wreg = 1; in_ex_rd = 5'd5;
        tick(); exp_stall++;
        in_ex_load = 0; in_ex_wreg = 0; in_ex_rd = 0;
        in_mem_load = 1; in_mem_wreg = 1; in_mem_rd = 5'd5;
        in_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (flags !== 4'b1100) begin n_bad++;
                $display("FAIL hold_flags[%0d] got=%b exp=1100", i, flags); end
            tick();
            n_cmp++; if ({out_state, out_stall_cnt} !== {2'd1, exp_stall}) begin
                n_bad++;
                $display("FAIL hold_frz[%0d] got=%0d/%0d exp=1/%0d",
                         i, out_state, out_stall_cnt, exp_stall); end
        end
        in_hold = 0;
        tick(); exp_stall++;
        in_mem_load = 0; in_mem_wreg = 0; in_mem_rd = 0;
        in_hold = 1;
        #1;
        n_cmp++; if (flags !== 4'b1000) begin n_bad++;
            $display("FAIL hold_run got=%b exp=1000", flags); end
        tick();
        in_hold = 0;
        #1;
        n_cmp++; if ({flags, out_redirect_pc} !== {4'b0001, 32'h0000_6000}) begin
            n_bad++;
            $display("FAIL hold_resume got=%b/%h exp=0001/00006000", flags, out_redirect_pc); end
        tick(); exp_taken++;
        n_cmp++; if ({out_taken_cnt, out_stall_cnt} !== {exp_taken, exp_stall}) begin
            n_bad++;
            $display("FAIL hold_cnts got=%0d/%0d exp=%0d/%0d",
                     out_taken_cnt, out_stall_cnt, exp_taken, exp_stall); end
        clr();
    endtask

    task automatic test_exc_reset;
        in_exception = 1;
        tick();
        #1;
        n_cmp++; if ({out_state, flags, out_redirect_pc} !== {2'd2, 4'b0011, 32'd4}) begin
            n_bad++;
            $display("FAIL exc_reissue got=%0d/%b/%h exp=2/0011/00000004",
                     out_state, flags, out_redirect_pc); end
        tick();
        in_exception = 0;
        #2;
        in_rst = 0;
        #1;
        n_cmp++; if ({out_state, flags, out_redirect_pc} !== 38'd0) begin n_bad++;
            $display("FAIL arst_outs got=%0d/%b/%h exp=0/0000/0",
                     out_state, flags, out_redirect_pc); end
        n_cmp++; if ({out_taken_cnt, out_stall_cnt} !== 32'd0) begin n_bad++;
            $display("FAIL arst_cnts got=%0d/%0d exp=0/0", out_taken_cnt, out_stall_cnt); end
        tick();
        in_rst = 1;
        exp_taken = 0; exp_stall = 0;
        tick();
    endtask

    task automatic test_wrap;
        id_set(6'h04, 6'h00, 5'd1, 5'd2, 32'h0000_7000);
        repeat (65535) tick();
        n_cmp++; if (out_taken_cnt !== 16'hFFFF) begin n_bad++;
            $display("FAIL wrap_max got=%h exp=ffff", out_taken_cnt); end
        tick();
        n_cmp++; if (out_taken_cnt !== 16'h0000) begin n_bad++;
            $display("FAIL wrap_zero got=%h exp=0000", out_taken_cnt); end
        clr();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_ignore();
        test_load_use();
        test_alu_jr();
        test_classes();
        test_exc_haz();
        test_hold();
        test_exc_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
